// File: rtl/pci_initiator.sv
// pci_initiator
// Sole bus master on the simplified PCI bus. Takes a local request for a
// 1..4 word memory read or write and runs the address phase, the data
// phases with IRDY/TRDY handshaking, and a master abort when no target
// claims the cycle with DEVSEL in time.
//
// Ports:
//   CLK, REST          bus clock, synchronous active-high reset
//   REQ, REQ_WRITE     start request (sampled in IDLE), direction
//   REQ_ADDR, REQ_LEN  start address (low two bits dropped), word count
//   REQ_BE             active-low byte enables used in every data phase
//   WBUF_*             loads the 4-word write buffer while not busy
//   RDATA/RDATA_VALID  last read word, one-clock pulse per captured word
//   BUSY, DONE, ABORT  transfer status
//   FRAME, IRDY, CBE   bus control (FRAME/IRDY active low)
//   AD                 multiplexed address/data, released when idle
//   TRDY, DEVSEL       target handshake inputs (active low)
module pci_initiator #(
  parameter logic [3:0] READ_OP        = 4'b0110,
  parameter logic [3:0] WRITE_OP       = 4'b0111,
  parameter int         DEVSEL_TIMEOUT = 5
) (
  input  logic        CLK,
  input  logic        REST,
  input  logic        REQ,
  input  logic        REQ_WRITE,
  input  logic [31:0] REQ_ADDR,
  input  logic [2:0]  REQ_LEN,
  input  logic [3:0]  REQ_BE,
  input  logic        WBUF_WE,
  input  logic [1:0]  WBUF_ADDR,
  input  logic [31:0] WBUF_DATA,
  output logic [31:0] RDATA,
  output logic        RDATA_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        ABORT,
  output logic        FRAME,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  input  logic        TRDY,
  input  logic        DEVSEL
);

  localparam int TO_W = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

  state_t          state, state_nxt;
  logic [31:0]     wbuf [4];
  logic            write_q;
  logic [31:0]     addr_q;
  logic [2:0]      len_q;
  logic [3:0]      be_q;
  logic [2:0]      word_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            devsel_seen;
  logic            abort_q;
  logic            ad_oe;
  logic [31:0]     ad_out;

  logic            req_ok;
  logic            phase_done;
  logic            last_phase;
  logic            to_hit;
  logic [2:0]      len_clamped;

  assign req_ok      = REQ && (REQ_LEN != 3'd0);
  assign len_clamped = (REQ_LEN > 3'd4) ? 3'd4 : REQ_LEN;
  assign phase_done  = (state == S_DATA) && !TRDY;
  assign last_phase  = (word_cnt == len_q - 3'd1);

  // Abort fires on the DATA clock that would make the DEVSEL-high count
  // reach the limit; a completing phase always wins over a timeout.
  assign to_hit = (state == S_DATA) && !phase_done && !devsel_seen && DEVSEL &&
                  (to_cnt == TO_W'(DEVSEL_TIMEOUT - 1));

  assign AD = ad_oe ? ad_out : 32'hzzzz_zzzz;

  // Write buffer is deliberately not reset; loads are locked out while a
  // transfer is running so the data under a burst cannot change.
  always_ff @(posedge CLK) begin
    if (WBUF_WE && !BUSY)
      wbuf[WBUF_ADDR] <= WBUF_DATA;
  end

  always_ff @(posedge CLK) begin
    if (REST)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state plus all bus outputs decoded from the registered state, so
  // a wait state (TRDY high) simply leaves everything where it was.
  always_comb begin
    state_nxt = state;
    FRAME     = 1'b1;
    IRDY      = 1'b1;
    CBE       = 4'hF;
    ad_oe     = 1'b0;
    ad_out    = 32'h0;
    case (state)
      S_IDLE: begin
        if (req_ok)
          state_nxt = S_ADDR;
      end
      S_ADDR: begin
        FRAME     = 1'b0;
        ad_oe     = 1'b1;
        ad_out    = addr_q;
        CBE       = write_q ? WRITE_OP : READ_OP;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        IRDY   = 1'b0;
        CBE    = be_q;
        FRAME  = last_phase;
        ad_oe  = write_q;
        ad_out = wbuf[word_cnt[1:0]];
        if ((phase_done && last_phase) || to_hit)
          state_nxt = S_END;
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign BUSY  = (state != S_IDLE);
  assign DONE  = (state == S_END) && !abort_q;
  assign ABORT = (state == S_END) && abort_q;

  // Request latch, word/timeout counters and read capture.
  always_ff @(posedge CLK) begin
    if (REST) begin
      write_q     <= 1'b0;
      addr_q      <= 32'h0;
      len_q       <= 3'd0;
      be_q        <= 4'h0;
      word_cnt    <= 3'd0;
      to_cnt      <= '0;
      devsel_seen <= 1'b0;
      abort_q     <= 1'b0;
      RDATA       <= 32'h0;
      RDATA_VALID <= 1'b0;
    end else begin
      RDATA_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            write_q  <= REQ_WRITE;
            addr_q   <= REQ_ADDR & 32'hFFFF_FFFC;
            len_q    <= len_clamped;
            be_q     <= REQ_BE;
            word_cnt <= 3'd0;
            abort_q  <= 1'b0;
          end
        end
        S_ADDR: begin
          to_cnt      <= '0;
          devsel_seen <= 1'b0;
        end
        S_DATA: begin
          if (!DEVSEL)
            devsel_seen <= 1'b1;
          else if (!devsel_seen)
            to_cnt <= to_cnt + TO_W'(1);
          if (phase_done) begin
            word_cnt <= word_cnt + 3'd1;
            if (!write_q) begin
              RDATA       <= AD;
              RDATA_VALID <= 1'b1;
            end
          end
          if (to_hit)
            abort_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_initiator.sv
// tb_pci_initiator
// Directed bench for pci_initiator. The stimulus process plays the target
// and checks bus signals clock by clock; read words, DONE and ABORT are
// pushed as expected events into a scoreboard queue that a separate
// monitor drains whenever the DUT pulses RDATA_VALID, DONE or ABORT.
module tb_pci_initiator;

  logic        CLK = 1'b0;
  logic        REST;
  logic        REQ;
  logic        REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [2:0]  REQ_LEN;
  logic [3:0]  REQ_BE;
  logic        WBUF_WE;
  logic [1:0]  WBUF_ADDR;
  logic [31:0] WBUF_DATA;
  logic [31:0] RDATA;
  logic        RDATA_VALID;
  logic        BUSY;
  logic        DONE;
  logic        ABORT;
  logic        FRAME;
  logic        IRDY;
  logic [3:0]  CBE;
  wire  [31:0] AD;
  logic        TRDY;
  logic        DEVSEL;

  logic        tgt_oe;
  logic [31:0] tgt_data;

  assign AD = tgt_oe ? tgt_data : 32'hzzzz_zzzz;

  typedef enum int {EV_RD, EV_DONE, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] wbuf_model [4];

  pci_initiator dut (
    .CLK(CLK), .REST(REST), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_BE(REQ_BE),
    .WBUF_WE(WBUF_WE), .WBUF_ADDR(WBUF_ADDR), .WBUF_DATA(WBUF_DATA),
    .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .BUSY(BUSY), .DONE(DONE),
    .ABORT(ABORT), .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE), .AD(AD),
    .TRDY(TRDY), .DEVSEL(DEVSEL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pushExp(input ev_kind_t kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sbPop(input ev_kind_t kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("[TB] FAIL sb_unexpected: got event %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      checkOutput("sb_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_RD) checkOutput("sb_rdata", data, e.data);
    end
  endtask

  // Scoreboard monitor, sampling mid-clock.
  always @(negedge CLK) begin
    if (DONE || ABORT) checkOutput("done_abort_excl", 32'(DONE & ABORT), 32'h0);
    if (RDATA_VALID) sbPop(EV_RD, RDATA);
    if (DONE)        sbPop(EV_DONE, 32'h0);
    if (ABORT)       sbPop(EV_ABORT, 32'h0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [2:0] len, input logic [3:0] be);
    REQ       = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = addr;
    REQ_LEN   = len;
    REQ_BE    = be;
    step();
    REQ = 1'b0;
  endtask

  // Drives a pattern from the target side; only reads back intact if the
  // DUT has released AD.
  task automatic checkReleased(input string name);
    tgt_oe   = 1'b1;
    tgt_data = 32'hDEAD_BEEF;
    #1;
    checkOutput(name, AD, 32'hDEAD_BEEF);
    tgt_oe = 1'b0;
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_frame"}, 32'(FRAME), 32'h1);
    checkOutput({name, "_irdy"},  32'(IRDY),  32'h1);
    checkOutput({name, "_cbe"},   32'(CBE),   32'hF);
    checkOutput({name, "_busy"},  32'(BUSY),  32'h0);
  endtask

  initial begin
    REST = 1'b1; REQ = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = 32'h0;
    REQ_LEN = 3'd0; REQ_BE = 4'h0; WBUF_WE = 1'b0; WBUF_ADDR = 2'd0;
    WBUF_DATA = 32'h0; TRDY = 1'b1; DEVSEL = 1'b1; tgt_oe = 1'b0;
    tgt_data = 32'h0;
    wbuf_model[0] = 32'h1111_1111; wbuf_model[1] = 32'h2222_2222;
    wbuf_model[2] = 32'h3333_3333; wbuf_model[3] = 32'h4444_4444;

    // Reset state
    step(); step();
    checkIdle("rst");
    checkOutput("rst_rdata", RDATA, 32'h0);
    checkOutput("rst_rvalid", 32'(RDATA_VALID), 32'h0);
    checkOutput("rst_done", 32'(DONE), 32'h0);
    checkOutput("rst_abort", 32'(ABORT), 32'h0);
    checkReleased("rst_ad_released");
    REST = 1'b0;
    step();

    // Load write buffer
    for (int i = 0; i < 4; i++) begin
      WBUF_WE = 1'b1; WBUF_ADDR = 2'(i); WBUF_DATA = wbuf_model[i];
      step();
    end
    WBUF_WE = 1'b0;

    // 4-word zero-wait write
    pushExp(EV_DONE, 32'h0);
    DEVSEL = 1'b0; TRDY = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_0000, 3'd4, 4'h0);
    checkOutput("w4_addr_ad", AD, 32'hFFFF_0000);
    checkOutput("w4_addr_frame", 32'(FRAME), 32'h0);
    checkOutput("w4_addr_irdy", 32'(IRDY), 32'h1);
    checkOutput("w4_addr_cbe", 32'(CBE), 32'h7);
    checkOutput("w4_addr_busy", 32'(BUSY), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("w4_data_ad", AD, wbuf_model[i]);
      checkOutput("w4_data_irdy", 32'(IRDY), 32'h0);
      checkOutput("w4_data_cbe", 32'(CBE), 32'h0);
      checkOutput("w4_data_frame", 32'(FRAME), (i == 3) ? 32'h1 : 32'h0);
    end
    step();
    DEVSEL = 1'b1; TRDY = 1'b1;
    checkOutput("w4_end_done", 32'(DONE), 32'h1);
    checkOutput("w4_end_frame", 32'(FRAME), 32'h1);
    checkOutput("w4_end_irdy", 32'(IRDY), 32'h1);
    checkOutput("w4_end_cbe", 32'(CBE), 32'hF);
    step();
    checkIdle("w4_idle");

    // 2-word read
    pushExp(EV_RD, 32'hA5A5_A5A5);
    pushExp(EV_RD, 32'h5A5A_5A5A);
    pushExp(EV_DONE, 32'h0);
    applyStimulus(1'b0, 32'hFFFF_0004, 3'd2, 4'h3);
    checkOutput("rd_addr_cbe", 32'(CBE), 32'h6);
    checkOutput("rd_addr_ad", AD, 32'hFFFF_0004);
    DEVSEL = 1'b0; TRDY = 1'b0;
    step();
    tgt_oe = 1'b1; tgt_data = 32'hA5A5_A5A5;
    #1;
    checkOutput("rd_d0_ad", AD, 32'hA5A5_A5A5);
    checkOutput("rd_d0_frame", 32'(FRAME), 32'h0);
    checkOutput("rd_d0_cbe", 32'(CBE), 32'h3);
    step();
    tgt_data = 32'h5A5A_5A5A;
    checkOutput("rd_d1_frame", 32'(FRAME), 32'h1);
    step();
    tgt_oe = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
    checkOutput("rd_end_done", 32'(DONE), 32'h1);
    step();
    checkIdle("rd_idle");
    checkOutput("rd_last_rdata", RDATA, 32'h5A5A_5A5A);

    // 1-word write with three wait states
    pushExp(EV_DONE, 32'h0);
    applyStimulus(1'b1, 32'h0000_2000, 3'd1, 4'h3);
    DEVSEL = 1'b0; TRDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("ws_ad", AD, 32'h1111_1111);
      checkOutput("ws_irdy", 32'(IRDY), 32'h0);
      checkOutput("ws_cbe", 32'(CBE), 32'h3);
      checkOutput("ws_frame", 32'(FRAME), 32'h1);
      checkOutput("ws_done", 32'(DONE), 32'h0);
      if (i == 3) TRDY = 1'b0;
    end
    step();
    DEVSEL = 1'b1; TRDY = 1'b1;
    checkOutput("ws_end_done", 32'(DONE), 32'h1);
    step();
    checkIdle("ws_idle");

    // Read with no target: master abort
    pushExp(EV_ABORT, 32'h0);
    applyStimulus(1'b0, 32'h0000_1000, 3'd2, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("ab_irdy", 32'(IRDY), 32'h0);
      checkOutput("ab_abort_early", 32'(ABORT), 32'h0);
    end
    step();
    checkOutput("ab_end_abort", 32'(ABORT), 32'h1);
    checkOutput("ab_end_done", 32'(DONE), 32'h0);
    step();
    checkIdle("ab_idle");
    checkReleased("ab_ad_released");

    // Reset during third data phase of a 4-word write
    DEVSEL = 1'b0; TRDY = 1'b0;
    applyStimulus(1'b1, 32'h0000_3000, 3'd4, 4'h0);
    step(); step(); step();
    checkOutput("rs_d2_ad", AD, 32'h3333_3333);
    REST = 1'b1;
    step();
    REST = 1'b0; DEVSEL = 1'b1; TRDY = 1'b1;
    checkIdle("rs");
    checkOutput("rs_done", 32'(DONE), 32'h0);
    checkOutput("rs_rdata", RDATA, 32'h0);
    checkReleased("rs_ad_released");

    // REQ with LEN 0 is ignored
    REQ = 1'b1; REQ_WRITE = 1'b1; REQ_LEN = 3'd0; REQ_ADDR = 32'h0000_4000;
    step();
    REQ = 1'b0;
    checkIdle("len0");

    // REQ and WBUF_WE held while busy are ignored
    pushExp(EV_DONE, 32'h0);
    DEVSEL = 1'b0; TRDY = 1'b0;
    REQ = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = 32'h0000_0100; REQ_LEN = 3'd1; REQ_BE = 4'h0;
    step();
    REQ_ADDR = 32'h0000_0200;
    WBUF_WE = 1'b1; WBUF_ADDR = 2'd0; WBUF_DATA = 32'h9999_9999;
    checkOutput("bz_addr_ad", AD, 32'h0000_0100);
    step();
    checkOutput("bz_data_ad", AD, 32'h1111_1111);
    step();
    REQ = 1'b0; WBUF_WE = 1'b0;
    checkOutput("bz_end_done", 32'(DONE), 32'h1);
    step();
    checkIdle("bz_idle");
    step();
    checkIdle("bz_idle2");

    // LEN 7 clamps to four data phases
    pushExp(EV_DONE, 32'h0);
    applyStimulus(1'b1, 32'h0000_0013, 3'd7, 4'hA);
    checkOutput("l7_addr_ad", AD, 32'h0000_0010);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("l7_data_ad", AD, wbuf_model[i]);
      checkOutput("l7_data_irdy", 32'(IRDY), 32'h0);
      checkOutput("l7_data_cbe", 32'(CBE), 32'hA);
      checkOutput("l7_data_frame", 32'(FRAME), (i == 3) ? 32'h1 : 32'h0);
    end
    step();
    DEVSEL = 1'b1; TRDY = 1'b1;
    checkOutput("l7_end_irdy", 32'(IRDY), 32'h1);
    checkOutput("l7_end_done", 32'(DONE), 32'h1);
    step();
    checkIdle("l7_idle");

    step(); step();
    checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
